// File: rtl/imagem_ram_scheduler_if.sv
// rtl/imagem_ram_scheduler_if.sv - CPU, scan, stream and RAM signals of the image RAM scheduler
interface imagem_ram_scheduler_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read;
  logic              cpu_write;
  logic [DATA_W-1:0] cpu_writedata;
  logic              cpu_waitrequest;
  logic [DATA_W-1:0] cpu_readdata;
  logic              cpu_readdatavalid;
  logic              scan_start;
  logic [ADDR_W-1:0] scan_base;
  logic [ADDR_W:0]   scan_len;
  logic              scan_busy;
  logic              scan_done;
  logic [DATA_W-1:0] st_data;
  logic              st_valid;
  logic              st_ready;
  logic              st_sop;
  logic              st_eop;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_write;
  logic [DATA_W-1:0] ram_writedata;
  logic [DATA_W-1:0] ram_readdata;

  modport master (
    output cpu_address, cpu_read, cpu_write, cpu_writedata,
    output scan_start, scan_base, scan_len, st_ready, ram_readdata,
    input  cpu_waitrequest, cpu_readdata, cpu_readdatavalid,
    input  scan_busy, scan_done, st_data, st_valid, st_sop, st_eop,
    input  ram_address, ram_write, ram_writedata
  );

  modport slave (
    input  cpu_address, cpu_read, cpu_write, cpu_writedata,
    input  scan_start, scan_base, scan_len, st_ready, ram_readdata,
    output cpu_waitrequest, cpu_readdata, cpu_readdatavalid,
    output scan_busy, scan_done, st_data, st_valid, st_sop, st_eop,
    output ram_address, ram_write, ram_writedata
  );
endinterface

// File: rtl/imagem_ram_scheduler.sv
// rtl/imagem_ram_scheduler.sv - round-robin sharing of one image RAM between CPU and a scan engine
module imagem_ram_scheduler #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic                   clk,
  input logic                   reset_n,
  imagem_ram_scheduler_if.slave bus_if
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LEN_W = ADDR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
  typedef enum logic {GNT_CPU, GNT_SCAN} grant_t;

  state_t            state_q, state_d;
  grant_t            last_q, last_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d, off_q, off_d, beat_q, beat_d;
  logic              done_q, done_d;
  logic              inflight_q, rd_pend_q;
  logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              start_ok, cpu_req, scan_req, cpu_gnt, scan_gnt;
  logic              push, pop, st_valid;
  logic [LEN_W-1:0]  cur_len, cur_off;
  logic [ADDR_W-1:0] scan_addr;

  // The first scan read is issued in the start cycle itself so a beat can appear 2 clk later.
  always_comb begin
    start_ok  = (state_q == IDLE) && bus_if.scan_start && (bus_if.scan_len != '0);
    cur_len   = (state_q == IDLE) ? bus_if.scan_len : len_q;
    cur_off   = (state_q == IDLE) ? '0 : off_q;
    scan_addr = ((state_q == IDLE) ? bus_if.scan_base : base_q) + cur_off[ADDR_W-1:0];
    cpu_req   = reset_n && (bus_if.cpu_read || bus_if.cpu_write);
    scan_req  = reset_n && (start_ok || (state_q == SCAN)) &&
                (({1'b0, cnt_q} + {{CNT_W{1'b0}}, inflight_q}) < DEPTH_C);
    cpu_gnt   = cpu_req && (!scan_req || (last_q == GNT_SCAN));
    scan_gnt  = scan_req && !cpu_gnt;
    st_valid  = (cnt_q != '0);
    push      = inflight_q;
    pop       = st_valid && bus_if.st_ready;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    base_d  = base_q;
    len_d   = len_q;
    off_d   = off_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q + CNT_W'(push) - CNT_W'(pop);
    if (cpu_gnt) begin
      last_d = GNT_CPU;
    end else if (scan_gnt) begin
      last_d = GNT_SCAN;
    end
    if (pop) begin
      beat_d = beat_q + LEN_W'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (bus_if.scan_start) begin
          base_d = bus_if.scan_base;
          len_d  = bus_if.scan_len;
          off_d  = '0;
          beat_d = '0;
          if (bus_if.scan_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
      end
      DRAIN: begin
        if (cnt_d == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (scan_gnt) begin
      off_d = cur_off + LEN_W'(1);
      if ((cur_off + LEN_W'(1)) == cur_len) begin
        state_d = DRAIN;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_q     <= GNT_SCAN;
      base_q     <= '0;
      len_q      <= '0;
      off_q      <= '0;
      beat_q     <= '0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      base_q     <= base_d;
      len_q      <= len_d;
      off_q      <= off_d;
      beat_q     <= beat_d;
      done_q     <= done_d;
      inflight_q <= scan_gnt;
      rd_pend_q  <= cpu_gnt && !bus_if.cpu_write;
      cnt_q      <= cnt_d;
      if (push) begin
        wr_q <= wr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_q <= rd_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_q] <= bus_if.ram_readdata;
    end
  end

  assign bus_if.cpu_waitrequest   = !cpu_gnt;
  assign bus_if.cpu_readdatavalid = rd_pend_q;
  assign bus_if.cpu_readdata      = rd_pend_q ? bus_if.ram_readdata : '0;
  assign bus_if.ram_address       = cpu_gnt ? bus_if.cpu_address : (scan_gnt ? scan_addr : '0);
  assign bus_if.ram_write         = cpu_gnt && bus_if.cpu_write;
  assign bus_if.ram_writedata     = cpu_gnt ? bus_if.cpu_writedata : '0;
  assign bus_if.scan_busy         = (state_q != IDLE);
  assign bus_if.scan_done         = done_q;
  assign bus_if.st_valid          = st_valid;
  assign bus_if.st_data           = st_valid ? fifo_q[rd_q] : '0;
  assign bus_if.st_sop            = st_valid && (beat_q == '0);
  assign bus_if.st_eop            = st_valid && (beat_q == (len_q - LEN_W'(1)));
endmodule

// File: tb/tb_imagem_ram_scheduler.sv
// tb/tb_imagem_ram_scheduler.sv - self-checking bench for imagem_ram_scheduler
module tb_imagem_ram_scheduler;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  imagem_ram_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if();
  imagem_ram_scheduler #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .bus_if(bus_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 37) ^ (a >> 8) ^ 8'h5C);
  endfunction

  // RAM model: 64K x 8, registered address, one cycle read latency
  logic [7:0] ram [65536];
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (bus_if.ram_write) ram[bus_if.ram_address] <= bus_if.ram_writedata;
      bus_if.ram_readdata <= ram[bus_if.ram_address];
    end
  end

  int rdy_mode = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) bus_if.st_ready = 1'b1;
      else if (rdy_mode == 1) bus_if.st_ready = ($urandom_range(3) != 0);
      else bus_if.st_ready = 1'b0;
    end
  end

  // Reference model: memory image in CPU-grant order plus an expected scan packet.
  logic [7:0] ref_mem [65536];
  logic [7:0] exp_arr [$];
  int exp_len = 0;
  int scan_id = 0;
  int start_cyc = 0;
  int d0 = 0;
  bit mon_en = 1'b0;
  int seen_id = 0;
  int beat_idx = 0;
  int first_v = -1;
  int done_cnt = 0;
  bit prev_rd = 1'b0;
  logic [7:0] rd_exp = '0;
  int streak = 0;

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (bus_if.scan_done) done_cnt++;
      if (scan_id != seen_id) begin
        seen_id = scan_id;
        beat_idx = 0;
        first_v = -1;
      end
      if (!mon_en) begin
        prev_rd = 1'b0;
        streak = 0;
      end else begin
        chk("cpu_rdv", bus_if.cpu_readdatavalid, prev_rd);
        if (prev_rd && bus_if.cpu_readdatavalid) chk("cpu_rdata", bus_if.cpu_readdata, rd_exp);
        prev_rd = 1'b0;
        if (bus_if.cpu_read || bus_if.cpu_write) begin
          if (bus_if.cpu_waitrequest) streak++;
          else streak = 0;
          chk("cpu_wait_le1", streak <= 1, 1);
          if (!bus_if.cpu_waitrequest) begin
            if (bus_if.cpu_write) ref_mem[bus_if.cpu_address] = bus_if.cpu_writedata;
            else begin
              prev_rd = 1'b1;
              rd_exp = ref_mem[bus_if.cpu_address];
            end
          end
        end else begin
          streak = 0;
        end
        if (bus_if.st_valid && first_v < 0) first_v = cyc;
        if (bus_if.st_valid && bus_if.st_ready) begin
          chk("beat_in_len", beat_idx < exp_len, 1);
          if (beat_idx < exp_arr.size()) chk("st_data", bus_if.st_data, exp_arr[beat_idx]);
          chk("st_sop", bus_if.st_sop, beat_idx == 0);
          chk("st_eop", bus_if.st_eop, beat_idx == exp_len - 1);
          beat_idx++;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    chk(name, {bus_if.cpu_waitrequest, bus_if.cpu_readdatavalid, bus_if.scan_busy, bus_if.scan_done,
               bus_if.st_valid, bus_if.st_sop, bus_if.st_eop, bus_if.ram_write}, 8'b1000_0000);
    chk({name, "_data"}, {bus_if.cpu_readdata, bus_if.st_data, bus_if.ram_writedata, bus_if.ram_address}, '0);
  endtask

  task automatic cpu_access(input bit wr, input logic [15:0] a, input logic [7:0] d, output int waits);
    @(posedge clk); #1;
    bus_if.cpu_write = wr;
    bus_if.cpu_read = !wr;
    bus_if.cpu_address = a;
    bus_if.cpu_writedata = d;
    waits = 0;
    @(negedge clk);
    while (bus_if.cpu_waitrequest && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus_if.cpu_write = 1'b0;
    bus_if.cpu_read = 1'b0;
  endtask

  task automatic cpu_traffic(input int ncycles, input bit allow_wr, input int req_pct);
    bit pending = 1'b0;
    for (int c = 0; c < ncycles; c++) begin
      @(posedge clk); #1;
      if (!pending) begin
        if ($urandom_range(99) < req_pct) begin
          pending = 1'b1;
          if (allow_wr && $urandom_range(1) == 1) begin
            bus_if.cpu_write = 1'b1;
            bus_if.cpu_read = 1'b0;
            bus_if.cpu_address = 16'h8000 | 16'($urandom_range(16'h7FFF));
            bus_if.cpu_writedata = 8'($urandom);
          end else begin
            bus_if.cpu_write = 1'b0;
            bus_if.cpu_read = 1'b1;
            bus_if.cpu_address = 16'($urandom);
          end
        end else begin
          bus_if.cpu_write = 1'b0;
          bus_if.cpu_read = 1'b0;
        end
      end
      @(negedge clk);
      if (pending && !bus_if.cpu_waitrequest) pending = 1'b0;
    end
    @(posedge clk); #1;
    bus_if.cpu_write = 1'b0;
    bus_if.cpu_read = 1'b0;
  endtask

  task automatic issue_start(input logic [15:0] base, input int len);
    @(posedge clk); #1;
    exp_arr.delete();
    for (int i = 0; i < len; i++) exp_arr.push_back(ref_mem[16'(base + i)]);
    exp_len = len;
    scan_id++;
    start_cyc = cyc;
    d0 = done_cnt;
    bus_if.scan_start = 1'b1;
    bus_if.scan_base = base;
    bus_if.scan_len = 17'(len);
    @(posedge clk); #1;
    bus_if.scan_start = 1'b0;
  endtask

  task automatic wait_scan(input int limit);
    int k = 0;
    while (done_cnt == d0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk("scan_done_once", done_cnt - d0, 1);
    chk("beat_count", beat_idx, exp_len);
    chk("busy_after_done", bus_if.scan_busy, 0);
  endtask

  typedef struct {
    bit         wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } vec_t;

  vec_t vecs [$];

  initial begin
    int waits;
    int k;
    int d1;
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits;
    int k;
    int d1;
    bus_if.cpu_address = '0;
    bus_if.cpu_read = 1'b0;
    bus_if.cpu_write = 1'b0;
    bus_if.cpu_writedata = '0;
    bus_if.scan_start = 1'b0;
    bus_if.scan_base = '0;
    bus_if.scan_len = '0;

    vecs.push_back('{1'b1, 16'h0010, 8'hA5});
    vecs.push_back('{1'b0, 16'h0010, 8'hA5});
    for (int i = 0; i < 8; i++) vecs.push_back('{1'b1, 16'(i), 8'(i)});
    vecs.push_back('{1'b0, 16'h0003, 8'h03});
    vecs.push_back('{1'b1, 16'hFFFE, 8'hE1});
    vecs.push_back('{1'b1, 16'hFFFF, 8'hE2});
    vecs.push_back('{1'b0, 16'hFFFF, 8'hE2});
    vecs.push_back('{1'b0, 16'h0007, 8'h07});

    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset_idle");
    mon_en = 1'b1;

    foreach (vecs[i]) begin
      cpu_access(vecs[i].wr, vecs[i].addr, vecs[i].data, waits);
      chk("table_wait", waits, 0);
      if (!vecs[i].wr) begin
        @(negedge clk);
        chk("table_rdv", bus_if.cpu_readdatavalid, 1);
        chk("table_rdata", bus_if.cpu_readdata, vecs[i].data);
      end
    end

    issue_start(16'h0000, 8);
    wait_scan(200);
    chk("first_beat_latency", first_v - start_cyc, 2);

    issue_start(16'hFFFE, 4);
    wait_scan(200);

    issue_start(16'h0050, 1);
    wait_scan(200);

    issue_start(16'h0100, 0);
    @(negedge clk);
    chk("len0_done", bus_if.scan_done, 1);
    chk("len0_busy", bus_if.scan_busy, 0);
    repeat (4) @(negedge clk);
    chk("len0_done_count", done_cnt - d0, 1);
    chk("len0_no_beats", beat_idx, 0);

    fork
      begin
        issue_start(16'h0200, 64);
        wait_scan(1000);
      end
      cpu_traffic(200, 1'b0, 100);
    join

    fork
      begin
        issue_start(16'h0300, 40);
        wait_scan(1500);
      end
      begin
        repeat (6) @(posedge clk);
        rdy_mode = 2;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (c >= 10 && (bus_if.cpu_read || bus_if.cpu_write))
            chk("stall_cpu_nowait", bus_if.cpu_waitrequest, 0);
        end
        rdy_mode = 0;
      end
      cpu_traffic(150, 1'b1, 100);
    join

    rdy_mode = 1;
    issue_start(16'h0400, 30);
    repeat (5) @(posedge clk);
    #1;
    bus_if.scan_start = 1'b1;
    bus_if.scan_base = 16'h1234;
    bus_if.scan_len = 17'd5;
    @(posedge clk); #1;
    bus_if.scan_start = 1'b0;
    wait_scan(1000);

    for (int r = 0; r < 6; r++) begin
      logic [15:0] base;
      int len;
      base = 16'($urandom_range(16'h7F00));
      len = $urandom_range(1, 150);
      fork
        begin
          issue_start(base, len);
          wait_scan(3000);
        end
        cpu_traffic(len * 2, 1'b1, 60);
      join
    end

    issue_start(16'h0600, 100);
    repeat (15) @(posedge clk);
    mon_en = 1'b0;
    #1;
    bus_if.cpu_read = 1'b1;
    bus_if.cpu_address = 16'h0010;
    k = 0;
    @(negedge clk);
    while (bus_if.cpu_waitrequest && k < 4) begin
      k++;
      @(negedge clk);
    end
    chk("pre_reset_accept", bus_if.cpu_waitrequest, 0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    bus_if.cpu_read = 1'b0;
    d1 = done_cnt;
    @(negedge clk);
    check_reset_outputs("reset_mid_scan");
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_done_after_abort", done_cnt - d1, 0);
    chk("idle_after_abort", {bus_if.scan_busy, bus_if.st_valid, bus_if.cpu_readdatavalid}, 3'b000);
    mon_en = 1'b1;
    rdy_mode = 0;

    issue_start(16'h0010, 3);
    wait_scan(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
